vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator with a registered pixel output stage.
- Successor to the fixed 640x480 generator. Adds configurable porches, sync widths and polarities, and colour depth.
- Exports pixel coordinates and frame/line strobes so a pixel source (game renderer) can feed colour back in.
- Runs in the pixel-clock domain, driven by the PLL output at the top level.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)
- COLOR_W, 4, bits per colour channel

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run when high; when low, raster is held at origin with outputs idle
- pix_red  in  COLOR_W  pixel-source red for current (x,y)
- pix_green  in  COLOR_W  pixel-source green
- pix_blue  in  COLOR_W  pixel-source blue
- x  out  XW=$clog2(H_TOTAL)  current horizontal count
- y  out  YW=$clog2(V_TOTAL)  current vertical count
- active  out  1  (x<H_ACTIVE)&&(y<V_ACTIVE)
- line_start  out  1  one-clock pulse when x==0
- frame_start  out  1  one-clock pulse when x==0&&y==0
- hsync  out  1  horizontal sync, pipelined
- vsync  out  1  vertical sync, pipelined
- red  out  COLOR_W  colour out, pipelined
- green  out  COLOR_W  colour out, pipelined
- blue  out  COLOR_W  colour out, pipelined
- blank  out  1  high outside active area, pipelined

Behaviour:
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP.
- Horizontal counter:
  - h_cnt increments every clock while enable=1.
  - At H_TOTAL-1 it wraps to 0 and v_cnt advances.
  - v_cnt wraps from V_TOTAL-1 to 0. Both counters wrap together at the frame end.
- Stage-0 signals (x, y, active, line_start, frame_start):
  - Combinational decodes of the registered counters: x=h_cnt, y=v_cnt.
  - The pixel source must present pix_* for (x,y) in the same cycle (combinational or prefetched).
- Stage 1: one register, one clock of latency.
  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL.
  - vsync = VSYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~VSYNC_POL.
  - vsync transitions are aligned to h_cnt==0.
  - blank = ~active.
  - red/green/blue = pix_* when active, else 0.
- Reset (reset=0, asynchronous):
  - h_cnt=0, v_cnt=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - blank=1, red=green=blue=0.
- Release:
  - First rising edge after reset deasserts is coordinate (0,0).
  - frame_start is high in that first cycle if enable=1.
- enable=0 (synchronous):
  - Counters forced to 0.
  - Stage 1 loads the reset/idle values.
  - Stage-0 strobes are gated low.
- enable rising:
  - Raster starts at (0,0) and frame_start pulses in that cycle.
- Mid-operation reset or enable drop:
  - The partial frame is abandoned. No runt sync pulse longer than the remaining width is generated.
- Elaboration check: any porch or sync parameter equal to 0 is illegal; assert it at elaboration.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - Adds input port pattern_sel (1 bit).
  - When pattern_sel=1, pix_* are ignored and stage 1 outputs 8 vertical colour bars. Bar index = x*8/H_ACTIVE, i.e. x[XW-1:0] scaled.
  - Bar k outputs red={COLOR_W{k[2]}}, green={COLOR_W{k[1]}}, blue={COLOR_W{k[0]}}.
  - Blanking and sync are unaffected.
- When undefined: no pattern_sel port; colour always comes from pix_*.

Test Plan:
- Small timing (H 8/2/3/1, V 4/1/2/1, totals 14x8), enable=1 after reset → frame_start pulses every 112 clocks; line_start every 14 clocks.
- Same config → hsync low for exactly 3 clocks, starting 1 clock after x==10; vsync low exactly 28 clocks, starting 1 clock after (x=0,y=5); blank low 8 clocks per line on lines 0..3.
- pix_red=x[3:0], pix_green=y, pix_blue=0xF → red equals the previous cycle's x during active; all colour outputs 0 while blank=1.
- HSYNC_POL=1, VSYNC_POL=1 → sync idles low, pulses high; otherwise identical timing.
- Assert reset low at (x=5,y=2) → outputs idle immediately (asynchronous); after release, x=0,y=0 and frame_start=1 on the first clock.
- enable low for 20 clocks mid-line → x,y stay 0, blank=1, syncs idle; enable high → frame_start pulses same cycle. With VGA_TEST_PATTERN_EN and pattern_sel=1 at 640 wide, x=80 → red=0,green=0,blue=0xF.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: stage-0 coordinate decodes plus one registered pixel stage.
// Optional colour-bar generator guarded by VGA_TEST_PATTERN_EN (adds the pattern_sel input).
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COLOR_W   = 4,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               pattern_sel,
`endif
  input  logic [COLOR_W-1:0] pix_red,
  input  logic [COLOR_W-1:0] pix_green,
  input  logic [COLOR_W-1:0] pix_blue,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               active,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               blank
);

  localparam logic [XW-1:0] H_LAST      = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_END   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SYNC_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SYNC_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST      = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_END   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SYNC_BEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SYNC_END  = YW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
    $error("vga_timing_gen: porch and sync widths must all be non-zero");
  end

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          active_raw;
  logic          h_sync_on;
  logic          v_sync_on;
  logic [COLOR_W-1:0] src_red;
  logic [COLOR_W-1:0] src_green;
  logic [COLOR_W-1:0] src_blue;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Both counters park at the origin while disabled, so enabling always starts a fresh frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + YW'(1);
    end else begin
      h_cnt <= h_cnt + XW'(1);
    end
  end

  assign active_raw = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign h_sync_on  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_sync_on  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  assign x           = h_cnt;
  assign y           = v_cnt;
  assign active      = enable && active_raw;
  assign line_start  = enable && (h_cnt == '0);
  assign frame_start = enable && (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_TEST_PATTERN_EN
  // Bar index = x*8/H_ACTIVE, built as a count of thresholds crossed to avoid a divider.
  logic [7:1] bar_hit;
  logic [2:0] bar;

  for (genvar gi = 1; gi < 8; gi++) begin : g_bar
    assign bar_hit[gi] = ({h_cnt, 3'b000} >= (XW+3)'(gi * H_ACTIVE));
  end

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      bar = bar + 3'(bar_hit[k]);
    end
  end

  assign src_red   = pattern_sel ? {COLOR_W{bar[2]}} : pix_red;
  assign src_green = pattern_sel ? {COLOR_W{bar[1]}} : pix_green;
  assign src_blue  = pattern_sel ? {COLOR_W{bar[0]}} : pix_blue;
`else
  assign src_red   = pix_red;
  assign src_green = pix_green;
  assign src_blue  = pix_blue;
`endif

  // Output stage; idling on disable cuts any sync pulse in progress rather than stretching it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      blank <= 1'b1;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (!enable) begin
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      blank <= 1'b1;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      hsync <= h_sync_on ? HSYNC_POL : ~HSYNC_POL;
      vsync <= v_sync_on ? VSYNC_POL : ~VSYNC_POL;
      blank <= ~active_raw;
      red   <= active_raw ? src_red   : '0;
      green <= active_raw ? src_green : '0;
      blue  <= active_raw ? src_blue  : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 14x8 raster, active-low and active-high sync instances side by side.
module tb_vga_timing_gen;

  localparam int HT = 14;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic clock;
  logic reset;
  logic enable;
  logic checking;

  logic [3:0] x0, x1;
  logic [2:0] y0, y1;
  logic       act0, act1, ls0, ls1, fs0, fs1, hs0, hs1, vs0, vs1, bl0, bl1;
  logic [3:0] r0, g0, b0, r1, g1, b1;
  logic [3:0] pr0, pg0, pr1, pg1;
  logic [3:0] pb;

  int checks = 0;
  int errors = 0;

  // Pixel source: red follows x, green follows y, blue constant.
  assign pr0 = x0;
  assign pg0 = {1'b0, y0};
  assign pr1 = x1;
  assign pg1 = {1'b0, y1};
  assign pb  = 4'hF;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(4)
  ) dut_lo (
    .clock(clock), .reset(reset), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .pix_red(pr0), .pix_green(pg0), .pix_blue(pb),
    .x(x0), .y(y0), .active(act0), .line_start(ls0), .frame_start(fs0),
    .hsync(hs0), .vsync(vs0), .red(r0), .green(g0), .blue(b0), .blank(bl0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_W(4)
  ) dut_hi (
    .clock(clock), .reset(reset), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .pix_red(pr1), .pix_green(pg1), .pix_blue(pb),
    .x(x1), .y(y1), .active(act1), .line_start(ls1), .frame_start(fs1),
    .hsync(hs1), .vsync(vs1), .red(r1), .green(g1), .blue(b1), .blank(bl1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Model: pixel index within the frame; coordinates and output stage derived arithmetically.
  int   mcount = 0;
  bit   e_hs_in = 1'b0;
  bit   e_vs_in = 1'b0;
  bit   e_blank = 1'b1;
  logic [3:0] e_r = '0, e_g = '0, e_b = '0;

  function automatic bit in_active(input int n);
    return ((n % HT) < 8) && ((n / HT) < 4);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset || !enable) begin
      mcount  <= 0;
      e_hs_in <= 1'b0;
      e_vs_in <= 1'b0;
      e_blank <= 1'b1;
      e_r     <= '0;
      e_g     <= '0;
      e_b     <= '0;
    end else begin
      e_hs_in <= ((mcount % HT) >= 10) && ((mcount % HT) < 13);
      e_vs_in <= ((mcount / HT) >= 5) && ((mcount / HT) < 7);
      e_blank <= !in_active(mcount);
      e_r     <= in_active(mcount) ? 4'(mcount % HT) : 4'd0;
      e_g     <= in_active(mcount) ? 4'(mcount / HT) : 4'd0;
      e_b     <= in_active(mcount) ? 4'hF : 4'd0;
      mcount  <= (mcount + 1) % FT;
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("x",           x0,   mcount % HT);
      chk("y",           y0,   mcount / HT);
      chk("active",      act0, enable && in_active(mcount));
      chk("line_start",  ls0,  enable && (mcount % HT == 0));
      chk("frame_start", fs0,  enable && (mcount == 0));
      chk("x_hi",        x1,   mcount % HT);
      chk("hsync_lo",    hs0,  !e_hs_in);
      chk("vsync_lo",    vs0,  !e_vs_in);
      chk("hsync_hi",    hs1,  e_hs_in);
      chk("vsync_hi",    vs1,  e_vs_in);
      chk("blank",       bl0,  e_blank);
      chk("blank_hi",    bl1,  e_blank);
      chk("red",         r0,   e_r);
      chk("green",       g0,   e_g);
      chk("blue",        b0,   e_b);
      chk("red_hi",      r1,   e_r);
    end
  end

  initial begin
    int  fs_first = -1, fs_second = -1, ls_count = 0;
    int  hs_low = 0, hs_first = -1, vs_low = 0, vs_first = -1, bl_low = 0, hs1_first = -1;
    bit  found;

    reset    = 1'b0;
    enable   = 1'b0;
    checking = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    checking = 1'b1;
    chk("rst_hsync_lo", hs0, 1);
    chk("rst_vsync_lo", vs0, 1);
    chk("rst_hsync_hi", hs1, 0);
    chk("rst_blank",    bl0, 1);
    chk("rst_red",      r0,  0);
    chk("rst_x",        x0,  0);

    enable = 1'b1;
    reset  = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge clock);
      if (fs0) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (ls0) ls_count++;
      if (i < FT) begin
        if (!hs0) begin hs_low++; if (hs_first < 0) hs_first = i; end
        if (!vs0) begin vs_low++; if (vs_first < 0) vs_first = i; end
        if (!bl0) bl_low++;
        if (hs1 && hs1_first < 0) hs1_first = i;
      end
      if (i == 5)  chk("lit_red_prev_x",   r0, 4);
      if (i == 9)  chk("lit_red_in_blank", r0, 0);
      if (i == 16) chk("lit_green_prev_y", g0, 1);
    end
    chk("lit_frame_first",  fs_first,  0);
    chk("lit_frame_period", fs_second, 112);
    chk("lit_line_count",   ls_count,  16);
    chk("lit_hsync_low",    hs_low,    24);
    chk("lit_hsync_first",  hs_first,  11);
    chk("lit_hsync_hi_1st", hs1_first, 11);
    chk("lit_vsync_low",    vs_low,    28);
    chk("lit_vsync_first",  vs_first,  71);
    chk("lit_blank_low",    bl_low,    32);

    // Asynchronous reset in the middle of an active line.
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clock);
      #2;
      if (x0 == 4'd5 && y0 == 3'd2) begin found = 1'b1; break; end
    end
    chk("reach_5_2", found, 1);
    chk("pre_rst_blank", bl0, 0);
    reset = 1'b0;
    #1;
    chk("async_x",      x0,  0);
    chk("async_y",      y0,  0);
    chk("async_blank",  bl0, 1);
    chk("async_red",    r0,  0);
    chk("async_hsync",  hs0, 1);
    chk("async_vsync",  vs0, 1);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock);
    chk("rel_x",  x0,  0);
    chk("rel_y",  y0,  0);
    chk("rel_fs", fs0, 1);

    // Drop enable inside an hsync pulse; the pulse must be cut, not stretched.
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clock);
      #2;
      if (x0 == 4'd12) begin found = 1'b1; break; end
    end
    chk("reach_x12", found, 1);
    chk("in_hsync", hs0, 0);
    enable = 1'b0;
    @(posedge clock);
    #1;
    chk("dis_hsync_cut", hs0, 1);
    repeat (20) begin
      @(negedge clock);
      chk("dis_x",     x0,  0);
      chk("dis_y",     y0,  0);
      chk("dis_blank", bl0, 1);
      chk("dis_hsync", hs0, 1);
      chk("dis_vsync", vs0, 1);
      chk("dis_ls",    ls0, 0);
    end
    @(posedge clock);
    #2;
    enable = 1'b1;
    #1;
    chk("en_fs", fs0, 1);
    repeat (150) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
